// File: rtl/i2s_play_sched.sv
// Playback scheduler for the I2S core: on each frame strobe, picks mute, loopback,
// a buffered stream frame, or the loopback/stream mix for the next transmit frame.
module i2s_play_sched #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DATAREADY,
  input  logic [W-1:0]     LEFT_OUT,
  input  logic [W-1:0]     RIGHT_OUT,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [W-1:0]     S_LEFT,
  input  logic [W-1:0]     S_RIGHT,
  output logic [W-1:0]     LEFT_IN,
  output logic [W-1:0]     RIGHT_IN,
  output logic             ACTIVE,
  output logic             UNDERRUN,
  output logic [CNT_W-1:0] UNDERRUN_CNT
);

  typedef enum logic [1:0] {ST_OFF, ST_SYNC, ST_RUN} state_t;

  state_t           r_state;
  logic [W-1:0]     r_memL [2];
  logic [W-1:0]     r_memR [2];
  logic             r_rdPtr;
  logic             r_wrPtr;
  logic [1:0]       r_count;
  logic             r_sReady;
  logic [W-1:0]     r_leftIn;
  logic [W-1:0]     r_rightIn;
  logic             r_active;
  logic             r_underrun;
  logic [CNT_W-1:0] r_underrunCnt;

  logic             w_frame;
  logic             w_needStream;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_underrun;
  logic [1:0]       w_countNext;
  logic [W-1:0]     w_headL;
  logic [W-1:0]     w_headR;
  logic [W:0]       w_sumL;
  logic [W:0]       w_sumR;
  logic [W-1:0]     w_mixL;
  logic [W-1:0]     w_mixR;

  assign w_frame      = (r_state == ST_RUN) && EN && DATAREADY;
  assign w_needStream = w_frame && MODE[1];
  assign w_empty      = (r_count == 2'd0);
  assign w_pop        = w_needStream && !w_empty;
  assign w_underrun   = w_needStream && w_empty;
  assign w_push       = S_VALID && r_sReady;

  // An empty FIFO contributes a zero stream term to both stream and mix modes.
  assign w_headL = w_empty ? '0 : r_memL[r_rdPtr];
  assign w_headR = w_empty ? '0 : r_memR[r_rdPtr];

  // Sum in W+1 bits and drop the LSB: floor((a+b)/2) always fits in W bits.
  assign w_sumL = {LEFT_OUT[W-1], LEFT_OUT} + {w_headL[W-1], w_headL};
  assign w_sumR = {RIGHT_OUT[W-1], RIGHT_OUT} + {w_headR[W-1], w_headR};
  assign w_mixL = W'(w_sumL >> 1);
  assign w_mixR = W'(w_sumR >> 1);

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop)
      w_countNext = r_count + 2'd1;
    else if (w_pop && !w_push)
      w_countNext = r_count - 2'd1;
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_memL[r_wrPtr] <= S_LEFT;
      r_memR[r_wrPtr] <= S_RIGHT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rdPtr  <= 1'b0;
      r_wrPtr  <= 1'b0;
      r_count  <= 2'd0;
      r_sReady <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop)  r_rdPtr <= ~r_rdPtr;
      r_count  <= w_countNext;
      r_sReady <= (w_countNext < 2'd2);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_OFF;
      r_leftIn      <= '0;
      r_rightIn     <= '0;
      r_active      <= 1'b0;
      r_underrun    <= 1'b0;
      r_underrunCnt <= '0;
    end else begin
      r_underrun <= w_underrun;
      if (w_underrun && (r_underrunCnt != {CNT_W{1'b1}}))
        r_underrunCnt <= r_underrunCnt + 1'b1;
      case (r_state)
        ST_OFF: begin
          r_leftIn  <= '0;
          r_rightIn <= '0;
          r_active  <= 1'b0;
          if (EN) r_state <= ST_SYNC;
        end
        ST_SYNC: begin
          r_leftIn  <= '0;
          r_rightIn <= '0;
          if (!EN) begin
            r_state <= ST_OFF;
          end else if (DATAREADY) begin
            r_state  <= ST_RUN;
            r_active <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!EN) begin
            r_state   <= ST_OFF;
            r_active  <= 1'b0;
            r_leftIn  <= '0;
            r_rightIn <= '0;
          end else if (DATAREADY) begin
            case (MODE)
              2'b00: begin r_leftIn <= '0;       r_rightIn <= '0;        end
              2'b01: begin r_leftIn <= LEFT_OUT; r_rightIn <= RIGHT_OUT; end
              2'b10: begin r_leftIn <= w_headL;  r_rightIn <= w_headR;   end
              default: begin r_leftIn <= w_mixL; r_rightIn <= w_mixR;    end
            endcase
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign S_READY      = r_sReady;
  assign LEFT_IN      = r_leftIn;
  assign RIGHT_IN     = r_rightIn;
  assign ACTIVE       = r_active;
  assign UNDERRUN     = r_underrun;
  assign UNDERRUN_CNT = r_underrunCnt;

endmodule

// File: tb/tb_i2s_play_sched.sv
// Directed self-checking bench for i2s_play_sched (CNT_W=4 so saturation is reachable).
module tb_i2s_play_sched;

  localparam int W     = 16;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic [1:0]       MODE = 2'b00;
  logic             DATAREADY = 1'b0;
  logic [W-1:0]     LEFT_OUT = '0;
  logic [W-1:0]     RIGHT_OUT = '0;
  logic             S_VALID = 1'b0;
  logic             S_READY;
  logic [W-1:0]     S_LEFT = '0;
  logic [W-1:0]     S_RIGHT = '0;
  logic [W-1:0]     LEFT_IN;
  logic [W-1:0]     RIGHT_IN;
  logic             ACTIVE;
  logic             UNDERRUN;
  logic [CNT_W-1:0] UNDERRUN_CNT;

  int checks = 0;
  int errors = 0;

  i2s_play_sched #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DATAREADY(DATAREADY),
    .LEFT_OUT(LEFT_OUT), .RIGHT_OUT(RIGHT_OUT), .S_VALID(S_VALID), .S_READY(S_READY),
    .S_LEFT(S_LEFT), .S_RIGHT(S_RIGHT), .LEFT_IN(LEFT_IN), .RIGHT_IN(RIGHT_IN),
    .ACTIVE(ACTIVE), .UNDERRUN(UNDERRUN), .UNDERRUN_CNT(UNDERRUN_CNT)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe();
    DATAREADY = 1'b1;
    step();
    DATAREADY = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    S_VALID = 1'b1;
    S_LEFT  = l;
    S_RIGHT = r;
    step();
    S_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    checks++; if (LEFT_IN !== 16'h0) begin errors++; $display("[TB] FAIL rst_left: got %h expected 0000", LEFT_IN); end
    checks++; if (RIGHT_IN !== 16'h0) begin errors++; $display("[TB] FAIL rst_right: got %h expected 0000", RIGHT_IN); end
    checks++; if (ACTIVE !== 1'b0) begin errors++; $display("[TB] FAIL rst_active: got %b expected 0", ACTIVE); end
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("[TB] FAIL rst_underrun: got %b expected 0", UNDERRUN); end
    checks++; if (UNDERRUN_CNT !== 4'h0) begin errors++; $display("[TB] FAIL rst_cnt: got %h expected 0", UNDERRUN_CNT); end
    checks++; if (S_READY !== 1'b0) begin errors++; $display("[TB] FAIL rst_sready: got %b expected 0", S_READY); end
    RST = 1'b0;
    step();
    checks++; if (S_READY !== 1'b1) begin errors++; $display("[TB] FAIL rel_sready: got %b expected 1", S_READY); end
  endtask

  task automatic test_loopback();
    EN   = 1'b1;
    MODE = 2'b01;
    step();
    LEFT_OUT  = 16'h1234;
    RIGHT_OUT = 16'hFEDC;
    strobe();
    checks++; if (LEFT_IN !== 16'h0) begin errors++; $display("[TB] FAIL sync_left: got %h expected 0000", LEFT_IN); end
    checks++; if (ACTIVE !== 1'b1) begin errors++; $display("[TB] FAIL sync_active: got %b expected 1", ACTIVE); end
    strobe();
    checks++; if (LEFT_IN !== 16'h1234) begin errors++; $display("[TB] FAIL loop_left: got %h expected 1234", LEFT_IN); end
    checks++; if (RIGHT_IN !== 16'hFEDC) begin errors++; $display("[TB] FAIL loop_right: got %h expected fedc", RIGHT_IN); end
  endtask

  task automatic test_stream_order();
    MODE = 2'b10;
    push(16'h0001, 16'h0002);
    push(16'h0003, 16'h0004);
    checks++; if (S_READY !== 1'b0) begin errors++; $display("[TB] FAIL full_sready: got %b expected 0", S_READY); end
    strobe();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0001_0002) begin errors++; $display("[TB] FAIL stream_a: got %h expected 00010002", {LEFT_IN, RIGHT_IN}); end
    checks++; if (S_READY !== 1'b1) begin errors++; $display("[TB] FAIL pop_sready: got %b expected 1", S_READY); end
    strobe();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0003_0004) begin errors++; $display("[TB] FAIL stream_b: got %h expected 00030004", {LEFT_IN, RIGHT_IN}); end
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("[TB] FAIL stream_b_ur: got %b expected 0", UNDERRUN); end
    strobe();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0) begin errors++; $display("[TB] FAIL stream_empty: got %h expected 00000000", {LEFT_IN, RIGHT_IN}); end
    checks++; if (UNDERRUN !== 1'b1) begin errors++; $display("[TB] FAIL stream_ur: got %b expected 1", UNDERRUN); end
    checks++; if (UNDERRUN_CNT !== 4'd1) begin errors++; $display("[TB] FAIL stream_cnt: got %0d expected 1", UNDERRUN_CNT); end
    step();
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("[TB] FAIL ur_pulse: got %b expected 0", UNDERRUN); end
  endtask

  task automatic test_mix();
    MODE = 2'b11;
    push(16'h7FFF, 16'hFFFF);
    LEFT_OUT  = 16'h7FFF;
    RIGHT_OUT = 16'h8000;
    strobe();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h7FFF_BFFF) begin errors++; $display("[TB] FAIL mix_ext: got %h expected 7fffbfff", {LEFT_IN, RIGHT_IN}); end
    push(16'h0000, 16'h0000);
    LEFT_OUT  = 16'h0001;
    RIGHT_OUT = 16'hFFFF;
    strobe();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0000_FFFF) begin errors++; $display("[TB] FAIL mix_round: got %h expected 0000ffff", {LEFT_IN, RIGHT_IN}); end
    checks++; if (UNDERRUN_CNT !== 4'd1) begin errors++; $display("[TB] FAIL mix_cnt: got %0d expected 1", UNDERRUN_CNT); end
    MODE      = 2'b01;
    LEFT_OUT  = 16'h5555;
    RIGHT_OUT = 16'h6666;
    step();
    step();
    step();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0000_FFFF) begin errors++; $display("[TB] FAIL mode_hold: got %h expected 0000ffff", {LEFT_IN, RIGHT_IN}); end
  endtask

  task automatic test_enable_priority();
    MODE = 2'b10;
    push(16'h1111, 16'h2222);
    EN        = 1'b0;
    DATAREADY = 1'b1;
    step();
    DATAREADY = 1'b0;
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0) begin errors++; $display("[TB] FAIL off_out: got %h expected 00000000", {LEFT_IN, RIGHT_IN}); end
    checks++; if (ACTIVE !== 1'b0) begin errors++; $display("[TB] FAIL off_active: got %b expected 0", ACTIVE); end
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("[TB] FAIL off_ur: got %b expected 0", UNDERRUN); end
    strobe();
    checks++; if ({LEFT_IN, ACTIVE} !== 17'h0) begin errors++; $display("[TB] FAIL off_ignore: got %h expected 00000", {LEFT_IN, ACTIVE}); end
    EN = 1'b1;
    step();
    strobe();
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("[TB] FAIL resync_ur: got %b expected 0", UNDERRUN); end
    strobe();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h1111_2222) begin errors++; $display("[TB] FAIL kept_frame: got %h expected 11112222", {LEFT_IN, RIGHT_IN}); end
    checks++; if (UNDERRUN_CNT !== 4'd1) begin errors++; $display("[TB] FAIL prio_cnt: got %0d expected 1", UNDERRUN_CNT); end
  endtask

  task automatic test_simultaneous();
    push(16'h000A, 16'h000B);
    push(16'h000C, 16'h000D);
    S_VALID   = 1'b1;
    S_LEFT    = 16'h00EE;
    S_RIGHT   = 16'h00FF;
    DATAREADY = 1'b1;
    step();
    S_VALID   = 1'b0;
    DATAREADY = 1'b0;
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h000A_000B) begin errors++; $display("[TB] FAIL sim_pop: got %h expected 000a000b", {LEFT_IN, RIGHT_IN}); end
    checks++; if (S_READY !== 1'b1) begin errors++; $display("[TB] FAIL sim_sready: got %b expected 1", S_READY); end
    strobe();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h000C_000D) begin errors++; $display("[TB] FAIL sim_second: got %h expected 000c000d", {LEFT_IN, RIGHT_IN}); end
    strobe();
    checks++; if ({UNDERRUN, UNDERRUN_CNT} !== 5'h12) begin errors++; $display("[TB] FAIL sim_nopush: got %h expected 12", {UNDERRUN, UNDERRUN_CNT}); end
    S_VALID   = 1'b1;
    S_LEFT    = 16'h0077;
    S_RIGHT   = 16'h0088;
    DATAREADY = 1'b1;
    step();
    S_VALID   = 1'b0;
    DATAREADY = 1'b0;
    checks++; if ({UNDERRUN, UNDERRUN_CNT} !== 5'h13) begin errors++; $display("[TB] FAIL empty_push_ur: got %h expected 13", {UNDERRUN, UNDERRUN_CNT}); end
    checks++; if (LEFT_IN !== 16'h0) begin errors++; $display("[TB] FAIL empty_push_out: got %h expected 0000", LEFT_IN); end
    strobe();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0077_0088) begin errors++; $display("[TB] FAIL stored_frame: got %h expected 00770088", {LEFT_IN, RIGHT_IN}); end
    strobe();
    checks++; if ({UNDERRUN, UNDERRUN_CNT} !== 5'h14) begin errors++; $display("[TB] FAIL one_entry: got %h expected 14", {UNDERRUN, UNDERRUN_CNT}); end
  endtask

  task automatic test_back_to_back();
    push(16'h0101, 16'h0202);
    push(16'h0303, 16'h0404);
    DATAREADY = 1'b1;
    step();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0101_0202) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 01010202", {LEFT_IN, RIGHT_IN}); end
    step();
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0303_0404) begin errors++; $display("[TB] FAIL b2b_second: got %h expected 03030404", {LEFT_IN, RIGHT_IN}); end
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ur: got %b expected 0", UNDERRUN); end
    step();
    DATAREADY = 1'b0;
    checks++; if ({UNDERRUN, UNDERRUN_CNT} !== 5'h15) begin errors++; $display("[TB] FAIL b2b_third: got %h expected 15", {UNDERRUN, UNDERRUN_CNT}); end
  endtask

  task automatic test_saturation();
    int expCnt;
    int pulses;
    expCnt = 5;
    pulses = 0;
    DATAREADY = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      if (UNDERRUN === 1'b1) pulses++;
      expCnt = (expCnt < 15) ? expCnt + 1 : 15;
      checks++; if (UNDERRUN_CNT !== expCnt[CNT_W-1:0]) begin errors++; $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", i, UNDERRUN_CNT, expCnt); end
    end
    DATAREADY = 1'b0;
    checks++; if (pulses != 19) begin errors++; $display("[TB] FAIL sat_pulses: got %0d expected 19", pulses); end
    step();
    checks++; if ({UNDERRUN, UNDERRUN_CNT} !== 5'h0F) begin errors++; $display("[TB] FAIL sat_hold: got %h expected 0f", {UNDERRUN, UNDERRUN_CNT}); end
  endtask

  task automatic test_reset_mid();
    MODE     = 2'b01;
    LEFT_OUT = 16'h4321;
    strobe();
    checks++; if (LEFT_IN !== 16'h4321) begin errors++; $display("[TB] FAIL pre_rst: got %h expected 4321", LEFT_IN); end
    push(16'h0055, 16'h0066);
    RST       = 1'b1;
    EN        = 1'b0;
    DATAREADY = 1'b1;
    step();
    DATAREADY = 1'b0;
    checks++; if ({LEFT_IN, RIGHT_IN} !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_out: got %h expected 00000000", {LEFT_IN, RIGHT_IN}); end
    checks++; if ({ACTIVE, UNDERRUN, S_READY} !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_flags: got %b expected 000", {ACTIVE, UNDERRUN, S_READY}); end
    checks++; if (UNDERRUN_CNT !== 4'h0) begin errors++; $display("[TB] FAIL mid_rst_cnt: got %0d expected 0", UNDERRUN_CNT); end
    RST = 1'b0;
    step();
    checks++; if (S_READY !== 1'b1) begin errors++; $display("[TB] FAIL mid_rel_sready: got %b expected 1", S_READY); end
    EN   = 1'b1;
    MODE = 2'b10;
    step();
    strobe();
    strobe();
    checks++; if ({UNDERRUN, UNDERRUN_CNT, LEFT_IN} !== 21'h11_0000) begin errors++; $display("[TB] FAIL fifo_flushed: got %h expected 110000", {UNDERRUN, UNDERRUN_CNT, LEFT_IN}); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stream_order();
    test_mix();
    test_enable_priority();
    test_simultaneous();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
